axi_mem_responder_m: RTL

AXI_MEM_RESPONDER_M -- requirements
Module: axi_mem_responder_m

---
 rtl/axi_mem_responder_m.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/axi_mem_responder_m.sv
// AXI4 memory responder: single-outstanding-burst slave backed by a word
// array. Writes take priority over reads; a read may be queued while the
// write response is pending and is served as soon as B completes.
module axi_mem_responder_m #(
  parameter  int DATA_W  = 64,
  parameter  int DEPTH   = 256,
  localparam int WSTRB_W = DATA_W / 8
) (
  input  logic               clk,
  input  logic               rst,
  // write address
  input  logic               awvalid,
  output logic               awready,
  input  logic [63:0]        awaddr,
  input  logic [7:0]         awlen,
  input  logic [2:0]         awsize,
  input  logic [1:0]         awburst,
  input  logic [1:0]         awid,
  input  logic [3:0]         awcache,
  input  logic               awlock,
  input  logic [2:0]         awprot,
  input  logic [3:0]         awqos,
  input  logic [3:0]         awregion,
  input  logic [17:0]        awuser,
  // write data
  input  logic               wvalid,
  output logic               wready,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [WSTRB_W-1:0] wstrb,
  input  logic               wlast,
  // write response
  output logic               bvalid,
  input  logic               bready,
  output logic [1:0]         bid,
  output logic [1:0]         bresp,
  // read address
  input  logic               arvalid,
  output logic               arready,
  input  logic [63:0]        araddr,
  input  logic [7:0]         arlen,
  input  logic [2:0]         arsize,
  input  logic [1:0]         arburst,
  input  logic [1:0]         arid,
  input  logic [3:0]         arcache,
  input  logic               arlock,
  input  logic [2:0]         arprot,
  input  logic [3:0]         arqos,
  input  logic [3:0]         arregion,
  input  logic [17:0]        aruser,
  // read data
  output logic               rvalid,
  input  logic               rready,
  output logic [DATA_W-1:0]  rdata,
  output logic [1:0]         rid,
  output logic [1:0]         rresp,
  output logic               rlast,
  // completion counters
  output logic [15:0]        wr_done,
  output logic [15:0]        rd_done
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OFS   = $clog2(WSTRB_W);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WRESP, S_READ} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0] wptr, rptr;
  logic [7:0]       wlen_q, wbeat, rlen_q, rbeat;
  logic [1:0]       wid_q, rid_q;
  logic             wfixed, werr, rfixed, rerr, ar_pend;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid  & wready;
  assign b_hs  = bvalid  & bready;
  assign ar_hs = arvalid & arready;
  assign r_hs  = rvalid  & rready;

  // Sideband and out-of-range address bits carry no meaning here.
  logic unused_sideband;
  assign unused_sideband = ^{awaddr, araddr, awcache, awlock, awprot, awqos, awregion,
                             awuser, arcache, arlock, arprot, arqos, arregion, aruser};

  // Only INCR/FIXED at full bus width are supported.
  function automatic logic ax_bad(input logic [1:0] burst, input logic [2:0] size);
    return !(burst == 2'b00 || burst == 2'b01) || (size != 3'(OFS));
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state: one burst at a time, write before read.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (aw_hs) state_nxt = S_WRITE;
               else if (ar_hs) state_nxt = S_READ;
      S_WRITE: if (w_hs && wbeat == wlen_q) state_nxt = S_WRESP;
      S_WRESP: if (b_hs) state_nxt = (ar_pend || ar_hs) ? S_READ : S_IDLE;
      S_READ:  if (r_hs && rbeat == rlen_q) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs; readies held low while reset is asserted.
  always_comb begin
    awready = 1'b0;
    arready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    rvalid  = 1'b0;
    if (rst) begin
      case (state)
        S_IDLE:  begin awready = 1'b1; arready = !awvalid; end
        S_WRITE: wready = 1'b1;
        S_WRESP: begin bvalid = 1'b1; arready = !ar_pend; end
        S_READ:  rvalid = 1'b1;
        default: ;
      endcase
    end
  end

  assign bid   = wid_q;
  assign bresp = (state == S_WRESP && werr) ? 2'b10 : 2'b00;
  assign rid   = rid_q;
  assign rresp = (state == S_READ && rerr) ? 2'b10 : 2'b00;
  assign rlast = (state == S_READ) && (rbeat == rlen_q);
  // Combinational read so a beat written on the previous cycle is visible.
  assign rdata = (state == S_READ && !rerr) ? mem[rptr] : '0;

  // Burst bookkeeping: pointers, beat counters, ids, error flags, counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0; wlen_q <= '0; wbeat <= '0; wid_q <= '0; wfixed <= 1'b0; werr <= 1'b0;
      rptr <= '0; rlen_q <= '0; rbeat <= '0; rid_q <= '0; rfixed <= 1'b0; rerr <= 1'b0;
      ar_pend <= 1'b0; wr_done <= '0; rd_done <= '0;
    end else begin
      if (aw_hs) begin
        wptr   <= awaddr[IDX_W+OFS-1:OFS];
        wlen_q <= awlen;
        wbeat  <= '0;
        wid_q  <= awid;
        wfixed <= (awburst == 2'b00);
        werr   <= ax_bad(awburst, awsize);
      end
      if (w_hs) begin
        wbeat <= wbeat + 8'd1;
        if (!wfixed) wptr <= wptr + 1'b1;
        // wlast must coincide exactly with the final beat
        if (wlast != (wbeat == wlen_q)) werr <= 1'b1;
      end
      if (ar_hs) begin
        rptr   <= araddr[IDX_W+OFS-1:OFS];
        rlen_q <= arlen;
        rbeat  <= '0;
        rid_q  <= arid;
        rfixed <= (arburst == 2'b00);
        rerr   <= ax_bad(arburst, arsize);
      end
      if (b_hs) ar_pend <= 1'b0;
      else if (ar_hs && state == S_WRESP) ar_pend <= 1'b1;
      if (r_hs) begin
        rbeat <= rbeat + 8'd1;
        if (!rfixed) rptr <= rptr + 1'b1;
      end
      if (b_hs) wr_done <= wr_done + 16'd1;
      if (r_hs && rbeat == rlen_q) rd_done <= rd_done + 16'd1;
    end
  end

  // Byte-lane memory write; storage itself is never reset.
  always_ff @(posedge clk) begin
    if (rst && w_hs && !werr)
      for (int i = 0; i < WSTRB_W; i++)
        if (wstrb[i]) mem[wptr][i*8 +: 8] <= wdata[i*8 +: 8];
  end
endmodule
